// File: rtl/me_wb_stage.sv
// ---------------------------------------------------------------------------
// me_wb_stage
//
// Memory-access / write-back stage directly downstream of the EX/ME pipeline
// register.
//
// Non-memory instructions retire one cycle after they are presented.
//
// Loads and stores go out on a variable-latency req/ack data-memory port.
// While an access is outstanding, upstream is stalled. The access is aborted
// on a misaligned address, or when no ack arrives within WAIT_MAX cycles.
//
// Handshake: dmem_req rises on the edge after an aligned memory op is
// captured. dmem_req, dmem_we, dmem_addr and dmem_wdata then stay constant
// until the edge on which dmem_ack is sampled high. dmem_rdata is taken on
// that same edge. dmem_ack is don't-care whenever dmem_req is low.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid          EX/ME holds a valid instruction
//   alu_res_in        ALU result / byte address for loads and stores
//   wr_reg_in         destination register
//   store_data_in     store data
//   Ctrl_Mem2Reg_in   load
//   Ctrl_regWr_in     instruction writes the register file
//   Ctrl_MemWr_in     store (wins over Ctrl_Mem2Reg_in when both set)
//   stall_out         upstream must hold EX/ME (high while in ACCESS)
//   dmem_*            data-memory request port
//   wb_valid          one-cycle pulse per retired instruction
//   wb_regWr, wb_reg, wb_data   register-file write-back
//   mem_err           one-cycle pulse on misaligned access or timeout
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module me_wb_stage #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_res_in,
    input  logic [4:0]  wr_reg_in,
    input  logic [31:0] store_data_in,
    input  logic        Ctrl_Mem2Reg_in,
    input  logic        Ctrl_regWr_in,
    input  logic        Ctrl_MemWr_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_regWr,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;

    // Captured instruction for the outstanding access.
    logic [4:0]    cap_reg_q;
    logic          cap_regwr_q;   // already cleared for stores
    logic          cap_load_q;    // Mem2Reg without MemWr
    logic [31:0]   cap_alu_q;

    // Registered output copies.
    logic          stall_q;
    logic          req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          wb_valid_q;
    logic          wb_regwr_q;
    logic [4:0]    wb_reg_q;
    logic [31:0]   wb_data_q;
    logic          mem_err_q;

    // Incoming instruction decode
    logic in_is_mem;
    logic in_misaligned;
    logic in_is_load;

    always_comb begin
        in_is_mem     = Ctrl_Mem2Reg_in | Ctrl_MemWr_in;
        in_misaligned = (alu_res_in[1:0] != 2'b00);
        // A store wins when both memory controls are set.
        in_is_load    = Ctrl_Mem2Reg_in & ~Ctrl_MemWr_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_reg_q   <= '0;
            cap_regwr_q <= 1'b0;
            cap_load_q  <= 1'b0;
            cap_alu_q   <= '0;
            stall_q     <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_regwr_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            // Pulses default low; wb_reg/wb_data/wb_regWr hold otherwise.
            wb_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!in_is_mem) begin
                            // Plain ALU op: retire next cycle.
                            wb_valid_q <= 1'b1;
                            wb_regwr_q <= Ctrl_regWr_in;
                            wb_reg_q   <= wr_reg_in;
                            wb_data_q  <= alu_res_in;
                        end else if (in_misaligned) begin
                            // Misaligned access: never reaches memory.
                            // wb_data keeps its previous value.
                            wb_valid_q <= 1'b1;
                            mem_err_q  <= 1'b1;
                            wb_regwr_q <= 1'b0;
                            wb_reg_q   <= wr_reg_in;
                        end else begin
                            cap_reg_q   <= wr_reg_in;
                            cap_regwr_q <= Ctrl_regWr_in & in_is_load;
                            cap_load_q  <= in_is_load;
                            cap_alu_q   <= alu_res_in;
                            req_q       <= 1'b1;
                            we_q        <= Ctrl_MemWr_in;
                            addr_q      <= alu_res_in;
                            wdata_q     <= store_data_in;
                            cnt_q       <= '0;
                            stall_q     <= 1'b1;
                            state_q     <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    // Inputs are ignored here; upstream is held by stall_out.
                    if (dmem_ack) begin
                        // Ack beats a simultaneous timeout.
                        req_q      <= 1'b0;
                        stall_q    <= 1'b0;
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        wb_reg_q   <= cap_reg_q;
                        wb_regwr_q <= cap_regwr_q;
                        wb_data_q  <= cap_load_q ? dmem_rdata : cap_alu_q;
                    end else if (cnt_q == CNT_LAST) begin
                        // Timeout: abort, report the error and retire without a write.
                        req_q      <= 1'b0;
                        stall_q    <= 1'b0;
                        state_q    <= IDLE;
                        wb_valid_q <= 1'b1;
                        mem_err_q  <= 1'b1;
                        wb_regwr_q <= 1'b0;
                        wb_reg_q   <= cap_reg_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_out  = stall_q;
        dmem_req   = req_q;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        wb_valid   = wb_valid_q;
        wb_regWr   = wb_regwr_q;
        wb_reg     = wb_reg_q;
        wb_data    = wb_data_q;
        mem_err    = mem_err_q;
    end

endmodule

// File: tb/tb_me_wb_stage.sv
module tb_me_wb_stage;
  localparam int WAIT_MAX = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [31:0] alu_res_in;
  logic [4:0]  wr_reg_in;
  logic [31:0] store_data_in;
  logic        Ctrl_Mem2Reg_in, Ctrl_regWr_in, Ctrl_MemWr_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_regWr;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mem_err;

  me_wb_stage #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .alu_res_in(alu_res_in),
    .wr_reg_in(wr_reg_in), .store_data_in(store_data_in),
    .Ctrl_Mem2Reg_in(Ctrl_Mem2Reg_in), .Ctrl_regWr_in(Ctrl_regWr_in),
    .Ctrl_MemWr_in(Ctrl_MemWr_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_regWr(wb_regWr), .wb_reg(wb_reg), .wb_data(wb_data), .mem_err(mem_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard record: {reg_known, err, regwr, reg[4:0], data[31:0]}
  logic [39:0] exp_q[$];

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        m2r, rw, mw;
    logic        e_valid, e_err, e_regwr;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        chk_data;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [31:0] sd, input logic m2r, input logic rw, input logic mw);
    in_valid        = v;
    alu_res_in      = alu;
    wr_reg_in       = rd;
    store_data_in   = sd;
    Ctrl_Mem2Reg_in = m2r;
    Ctrl_regWr_in   = rw;
    Ctrl_MemWr_in   = mw;
  endtask

  task automatic drive_garbage();
    drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall_out, 0);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_regwr"}, wb_regWr, 0);
    chk({tag, "_wb_reg"}, wb_reg, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_mem_err"}, mem_err, 0);
  endtask

  task automatic sb_check();
    logic [39:0] rec;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: wb_valid got 1 expected 0 (no pending record)");
    end else begin
      rec = exp_q.pop_front();
      chk("sb_err", mem_err, rec[38]);
      chk("sb_regwr", wb_regWr, rec[37]);
      if (rec[39]) chk("sb_reg", wb_reg, rec[36:32]);
      if (!rec[38]) chk("sb_data", wb_data, rec[31:0]);
    end
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] addr, rdata, sd;
    logic [4:0]  rd;
    logic        rw, m2r, mw, is_store;
    int          kind, d;

    // ---------------- reset ----------------
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(1'b1, 32'h40, 5'd3, 32'h1, 1'b0, 1'b1, 1'b0);
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // ---------------- table vectors (single-cycle, from IDLE) ----------------
    vecs[0] = '{1'b1, 32'h11, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h11, 1'b1};
    vecs[1] = '{1'b1, 32'h22, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 32'h22, 1'b1};
    vecs[2] = '{1'b1, 32'h33, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h33, 1'b1};
    vecs[3] = '{1'b0, 32'h99, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h33, 1'b1};
    vecs[4] = '{1'b1, 32'h55, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h55, 1'b1};
    vecs[5] = '{1'b1, 32'h102, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 32'h203, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0};
    vecs[8] = '{1'b1, 32'h1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h0, 1'b0};
    vecs[9] = '{1'b1, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].alu, vecs[i].rd, $urandom, vecs[i].m2r, vecs[i].rw, vecs[i].mw);
      dmem_ack = 1'b1;  // ignored: no request outstanding
      step();
      chk($sformatf("vec%0d_valid", i), wb_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_err", i), mem_err, vecs[i].e_err);
      chk($sformatf("vec%0d_regwr", i), wb_regWr, vecs[i].e_regwr);
      chk($sformatf("vec%0d_reg", i), wb_reg, vecs[i].e_reg);
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), wb_data, vecs[i].e_data);
      chk($sformatf("vec%0d_req", i), dmem_req, 0);
      chk($sformatf("vec%0d_stall", i), stall_out, 0);
    end
    dmem_ack = 1'b0;

    // ---------------- load 0x100 -> r9, ack on 3rd ACCESS cycle ----------------
    drive(1'b1, 32'h100, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h44, 5'd10, 32'h0, 1'b0, 1'b1, 1'b0);  // held upstream
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ld_req_c%0d", i), dmem_req, 1);
      chk($sformatf("ld_we_c%0d", i), dmem_we, 0);
      chk($sformatf("ld_addr_c%0d", i), dmem_addr, 32'h100);
      chk($sformatf("ld_stall_c%0d", i), stall_out, 1);
      chk($sformatf("ld_wbv_c%0d", i), wb_valid, 0);
      if (i == 2) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    dmem_ack = 1'b0;
    chk("ld_done_req", dmem_req, 0);
    chk("ld_done_stall", stall_out, 0);
    chk("ld_done_valid", wb_valid, 1);
    chk("ld_done_reg", wb_reg, 9);
    chk("ld_done_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_done_regwr", wb_regWr, 1);
    chk("ld_done_err", mem_err, 0);
    step();
    chk("held_valid", wb_valid, 1);
    chk("held_reg", wb_reg, 10);
    chk("held_data", wb_data, 32'h44);
    drive(1'b0, 0, 0, 0, 0, 0, 0);

    // ---------------- store 0x204, ack in first ACCESS cycle ----------------
    drive(1'b1, 32'h204, 5'd3, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h204);
    chk("st_wdata", dmem_wdata, 32'hCAFE_F00D);
    chk("st_stall", stall_out, 1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("st_done_valid", wb_valid, 1);
    chk("st_done_regwr", wb_regWr, 0);
    chk("st_done_reg", wb_reg, 3);
    chk("st_done_data", wb_data, 32'h204);
    chk("st_done_stall", stall_out, 0);
    chk("st_done_req", dmem_req, 0);

    // ---------------- load with no ack: timeout ----------------
    drive(1'b1, 32'h300, 5'd11, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < WAIT_MAX; i++) begin
      chk($sformatf("to_req_c%0d", i), dmem_req, 1);
      chk($sformatf("to_wbv_c%0d", i), wb_valid, 0);
      step();
    end
    chk("to_req_drop", dmem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_valid", wb_valid, 1);
    chk("to_regwr", wb_regWr, 0);
    chk("to_stall", stall_out, 0);
    step();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h1234_5678;
    step();
    dmem_ack = 1'b0;
    chk("late_ack_valid", wb_valid, 0);
    chk("late_ack_err", mem_err, 0);
    chk("late_ack_req", dmem_req, 0);

    // ---------------- ack on the last allowed cycle wins ----------------
    drive(1'b1, 32'h400, 5'd13, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < WAIT_MAX - 1; i++) step();
    chk("aw_req_last", dmem_req, 1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    step();
    dmem_ack = 1'b0;
    chk("aw_valid", wb_valid, 1);
    chk("aw_err", mem_err, 0);
    chk("aw_data", wb_data, 32'h0BAD_F00D);
    chk("aw_regwr", wb_regWr, 1);

    // ---------------- reset during ACCESS ----------------
    drive(1'b1, 32'h500, 5'd14, 32'h7777_7777, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rm_req_before", dmem_req, 1);
    rst = 1'b1;
    step();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    drive(1'b1, 32'h66, 5'd15, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", wb_valid, 1);
    chk("post_rst_reg", wb_reg, 15);
    chk("post_rst_data", wb_data, 32'h66);
    step();

    // ---------------- randomized run against reference model ----------------
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      dmem_ack = 1'($urandom_range(0, 1));  // no request pending: must be ignored
      dmem_rdata = $urandom;
      rd = 5'($urandom);
      rw = 1'($urandom_range(0, 1));
      sd = $urandom;
      if (kind < 2) begin
        drive(1'b0, $urandom, rd, sd, 1'($urandom_range(0, 1)), rw, 1'($urandom_range(0, 1)));
        step();
        chk("r_idle_valid", wb_valid, 0);
        chk("r_idle_err", mem_err, 0);
        chk("r_idle_req", dmem_req, 0);
      end else if (kind < 6) begin
        addr = $urandom;
        drive(1'b1, addr, rd, sd, 1'b0, rw, 1'b0);
        exp_q.push_back({1'b1, 1'b0, rw, rd, addr});
        step();
        chk("r_alu_valid", wb_valid, 1);
        if (wb_valid) sb_check();
        chk("r_alu_stall", stall_out, 0);
      end else begin
        if (kind < 8) begin m2r = 1'b1; mw = 1'b0; end
        else begin m2r = 1'($urandom_range(0, 1)); mw = 1'b1; end
        is_store = mw;
        addr = $urandom;
        if ($urandom_range(0, 4) == 0) begin
          if (addr[1:0] == 2'b00) addr[0] = 1'b1;
          drive(1'b1, addr, rd, sd, m2r, rw, mw);
          exp_q.push_back({1'b1, 1'b1, 1'b0, rd, 32'h0});
          step();
          chk("r_mis_valid", wb_valid, 1);
          if (wb_valid) sb_check();
          chk("r_mis_req", dmem_req, 0);
        end else begin
          addr[1:0] = 2'b00;
          drive(1'b1, addr, rd, sd, m2r, rw, mw);
          step();
          chk("r_mem_req", dmem_req, 1);
          chk("r_mem_we", dmem_we, is_store);
          chk("r_mem_addr", dmem_addr, addr);
          chk("r_mem_wdata", dmem_wdata, sd);
          chk("r_mem_stall", stall_out, 1);
          d = $urandom_range(0, WAIT_MAX + 1);
          dmem_ack = 1'b0;
          if (d < WAIT_MAX) begin
            for (int i = 0; i < d; i++) begin
              drive_garbage();
              step();
              chk("r_wait_req", dmem_req, 1);
              chk("r_wait_addr", dmem_addr, addr);
              chk("r_wait_valid", wb_valid, 0);
            end
            drive_garbage();
            dmem_ack = 1'b1;
            rdata = $urandom;
            dmem_rdata = rdata;
            exp_q.push_back({1'b1, 1'b0, is_store ? 1'b0 : rw, rd, is_store ? addr : rdata});
            step();
            dmem_ack = 1'b0;
            chk("r_done_valid", wb_valid, 1);
            if (wb_valid) sb_check();
            chk("r_done_req", dmem_req, 0);
            chk("r_done_stall", stall_out, 0);
          end else begin
            for (int i = 0; i < WAIT_MAX - 1; i++) begin
              drive_garbage();
              step();
              chk("r_to_req", dmem_req, 1);
            end
            drive_garbage();
            exp_q.push_back({1'b0, 1'b1, 1'b0, rd, 32'h0});
            step();
            chk("r_to_valid", wb_valid, 1);
            if (wb_valid) sb_check();
            chk("r_to_req_drop", dmem_req, 0);
          end
        end
      end
    end

    chk("sb_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
